csr_commit_ctrl: RTL
====================

# csr_commit_ctrl

Write-back-stage commit controller: the initiator side of the CSR register file interface. It latches one instruction per cycle from the MEM stage and commits CSR reads and writes. It raises exceptions, ERTN and interrupts toward the CSR file, redirects fetch, and squashes wrong-path instructions during a flush window.

## Interface
- FLUSH_CYCLES, 1, cycles of wrong-path squash after a redirect (legal 1..15)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ms_valid  in  1  MEM stage offers an instruction
- ws_allowin  out  1  WB accepts this cycle
- ms_pc, ms_vaddr  in  32 each  instruction PC / faulting data address
- ms_op_csrrd, ms_op_csrwr, ms_op_csrxchg, ms_op_ertn  in  1 each  one-hot op class (all 0 = ordinary)
- ms_csr_num  in  14  CSR index
- ms_rd_value, ms_rj_value  in  32 each  write value / xchg mask
- ms_ex  in  1  upstream exception; ms_ecode 6, ms_esubcode 9
- ms_gr_we  in  1  GPR write; ms_dest 5; ms_result 32
- rf_we  out 1; rf_waddr  out 5; rf_wdata  out 32  GPR write port
- csr_re, csr_we  out 1 each; csr_num  out 14; csr_wmask, csr_wvalue  out 32 each; csr_rvalue  in  32
- wb_ex, ertn_flush  out  1 each; wb_csr_pc, wb_vaddr  out 32; wb_ecode  out 6; wb_esubcode  out 9
- ex_entry, ertn_entry  in  32 each  redirect targets from CSR file
- has_int  in  1  pending enabled interrupt
- flush  out  1  redirect pulse to fetch; flush_pc  out  32
- ws_csr_blk  out  1  valid CSR-class instruction in WB (ID hazard stall)

## Operation
- WB register (ws_valid + captured fields) loads when ms_valid && ws_allowin; ws_allowin = 1 always (single-cycle WB).
- States: RUN, SQUASH. RUN: a loaded instruction commits in the cycle it sits in WB. SQUASH: incoming instructions are accepted but loaded with ws_valid=0; a 4-bit counter counts down from FLUSH_CYCLES; SQUASH->RUN on the cycle the counter reaches 0.
- Commit priority, highest first:
  1. Interrupt: ws_valid && int_tag. wb_ex=1, wb_ecode=0x00, wb_esubcode=0.
  2. Upstream exception: wb_ex=1 with captured ecode/esubcode.
  3. ERTN: ertn_flush=1.
  4. CSR op.
  5. Ordinary instruction.
- Exception/interrupt/ERTN: no rf_we, no csr_we; flush=1; flush_pc = ex_entry (exception, interrupt) or ertn_entry (ERTN); enter SQUASH.
- csrrd: csr_re=1, csr_we=0. csrwr: csr_we=1, wmask=32'hFFFFFFFF. csrxchg: csr_we=1, wmask=rj_value. For csrwr/csrxchg, wvalue=rd_value.
- CSR ops: rf_wdata = csr_rvalue (old value), rf_we=gr_we. Ordinary: rf_wdata = result.
- csr_num, wb_csr_pc, wb_vaddr always drive the WB-register fields. Every strobe (rf_we, csr_we, csr_re, wb_ex, ertn_flush, flush) is gated by ws_valid.
- int_tag: set at load time when has_int=1 and state=RUN.

## Timing
- Reset: ws_valid=0, state RUN, counter 0, all strobes 0, all data outputs 0.
- MEM handshake cycle N -> commit strobes in cycle N+1 (combinational from the WB register); CSR file updates at end of N+1.
- flush is a single-cycle pulse. An instruction offered in that cycle or in the next FLUSH_CYCLES-1 cycles is discarded.
- A flush arriving while in SQUASH cannot occur (nothing valid commits in SQUASH).
- Reset during SQUASH: RUN, counter 0, next cycle accepts normally.
- has_int toggling while WB is empty or in SQUASH is ignored; it is sampled only at load in RUN.

## Configuration
- CSR_CTRL_INT_EN defined: interrupt tagging as above.
- Undefined: int_tag is tied to 0 and has_int is unused. The port remains, and priority starts at upstream exception.

## Structure
- ECODE constants (ECODE_INT=0x00, ECODE_ADE, ECODE_ALE, ECODE_SYS) and CSR numbers live in the shared defines.vh; no new constants local to the block.
- One sub-module, squash_timer: counter load/decrement, done flag, reset.

## Test plan
- csrwr to SAVE0, rd_value=0x12345678, dest=5 -> csr_we=1, wmask=0xFFFFFFFF, rf_we=1, rf_waddr=5, rf_wdata = prior SAVE0 value, the cycle after handshake.
- csrxchg rj=0x0000FF00, rd=0xAAAAAAAA -> csr_wmask=0x0000FF00, csr_wvalue=0xAAAAAAAA.
- ms_ex=1, ecode=0x0B (SYS), pc=0x1C000100, ex_entry=0x1C008000 -> wb_ex=1, wb_csr_pc=0x1C000100, flush=1, flush_pc=0x1C008000, no rf_we. With FLUSH_CYCLES=2, the next two offered instructions produce no strobes; the third commits.
- ERTN with ertn_entry=0x1C000200 -> ertn_flush=1, flush_pc=0x1C000200, wb_ex=0.
- CSR_CTRL_INT_EN defined, has_int=1 at load of a csrwr -> wb_ex=1, wb_ecode=0, csr_we=0. Macro undefined: the same stimulus commits the csrwr normally.
- Assert resetn=0 during SQUASH -> all strobes 0 next cycle; the first instruction after release commits.

Source files
------------

// File: rtl/csr_commit_ctrl_pkg.sv
// Shared WB/CSR definitions: exception codes, CSR indices, WB state and register layout.
package csr_commit_ctrl_pkg;

  localparam logic [5:0]  ECODE_INT = 6'h00;
  localparam logic [5:0]  ECODE_ADE = 6'h08;
  localparam logic [5:0]  ECODE_ALE = 6'h09;
  localparam logic [5:0]  ECODE_SYS = 6'h0B;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000C;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;

  typedef enum logic {RUN, SQUASH} wb_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        op_csrrd;
    logic        op_csrwr;
    logic        op_csrxchg;
    logic        op_ertn;
    logic [13:0] csr_num;
    logic [31:0] rd_value;
    logic [31:0] rj_value;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        int_tag;
  } ws_reg_t;

endpackage

// File: rtl/csr_commit_ctrl_squash.sv
// Squash window timer: loads on a redirect, counts down, flags the last squash cycle.
module squash_timer #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic done
);

  // The redirect cycle itself is the first cycle of the window.
  localparam logic [3:0] LOAD = 4'(FLUSH_CYCLES - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn)         cnt <= 4'd0;
    else if (start)      cnt <= LOAD;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign done = (cnt == 4'd1);

endmodule

// File: rtl/csr_commit_ctrl.sv
// WB-stage commit controller driving the CSR file, GPR write port and fetch redirect.
// Interrupt tagging is built only when CSR_CTRL_INT_EN is defined.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_op_csrrd,
  input  logic        ms_op_csrwr,
  input  logic        ms_op_csrxchg,
  input  logic        ms_op_ertn,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rd_value,
  input  logic [31:0] ms_rj_value,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_csr_pc,
  output logic [31:0] wb_vaddr,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  input  logic        has_int,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        ws_csr_blk
);

  wb_state_t state;
  logic      ws_valid;
  ws_reg_t   ws;
  logic      timer_done;
  logic      load_valid;
  logic      int_tag_in;
  logic      csr_op;
  logic      commit_ok;

  assign ws_allowin = 1'b1;

`ifdef CSR_CTRL_INT_EN
  assign int_tag_in = has_int && (state == RUN);
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_tag_in     = 1'b0;
`endif

  // Wrong-path instructions are still accepted, but land in WB as bubbles.
  assign load_valid = ms_valid && ws_allowin && (state == RUN) && !flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws       <= '0;
    end else begin
      ws_valid <= load_valid;
      if (ms_valid && ws_allowin) begin
        ws <= '{pc: ms_pc, vaddr: ms_vaddr, op_csrrd: ms_op_csrrd,
                op_csrwr: ms_op_csrwr, op_csrxchg: ms_op_csrxchg,
                op_ertn: ms_op_ertn, csr_num: ms_csr_num,
                rd_value: ms_rd_value, rj_value: ms_rj_value, ex: ms_ex,
                ecode: ms_ecode, esubcode: ms_esubcode, gr_we: ms_gr_we,
                dest: ms_dest, result: ms_result, int_tag: int_tag_in};
      end
    end
  end

  // Commit stage: strobes are combinational from the WB register.
  assign csr_op    = ws.op_csrrd || ws.op_csrwr || ws.op_csrxchg;
  assign commit_ok = ws_valid && !ws.int_tag && !ws.ex && !ws.op_ertn;

  assign wb_ex       = ws_valid && (ws.int_tag || ws.ex);
  assign wb_ecode    = ws.int_tag ? ECODE_INT : ws.ecode;
  assign wb_esubcode = ws.int_tag ? 9'd0 : ws.esubcode;
  assign ertn_flush  = ws_valid && !ws.int_tag && !ws.ex && ws.op_ertn;
  assign flush       = wb_ex || ertn_flush;
  assign flush_pc    = ertn_flush ? ertn_entry : (wb_ex ? ex_entry : 32'd0);
  assign wb_csr_pc   = ws.pc;
  assign wb_vaddr    = ws.vaddr;

  assign csr_re     = commit_ok && csr_op;
  assign csr_we     = commit_ok && (ws.op_csrwr || ws.op_csrxchg);
  assign csr_num    = ws.csr_num;
  assign csr_wmask  = ws.op_csrwr ? 32'hFFFF_FFFF : (ws.op_csrxchg ? ws.rj_value : 32'd0);
  assign csr_wvalue = ws.rd_value;

  assign rf_we    = commit_ok && ws.gr_we;
  assign rf_waddr = ws.dest;
  assign rf_wdata = csr_op ? csr_rvalue : ws.result;

  assign ws_csr_blk = ws_valid && (csr_op || ws.op_ertn);

  squash_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_squash_timer (
    .clk    (clk),
    .resetn (resetn),
    .start  (flush),
    .done   (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (flush && (FLUSH_CYCLES > 1)) state <= SQUASH;
        SQUASH:  if (timer_done) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
